// File: rtl/bf_pkg.sv
// Shared opcode and state definitions for the Brainfuck fetch controller.
package bf_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_IN   = 3'b000,
    OP_OUT  = 3'b001,
    OP_BACK = 3'b010,
    OP_IF   = 3'b011,
    OP_MOVL = 3'b100,
    OP_MOVR = 3'b101,
    OP_DEC  = 3'b110,
    OP_INC  = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_SKIP = 3'd2,
    ST_HALT = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // Everything except the two bracket opcodes goes to the execute unit.
  function automatic logic is_data_op(input logic [OP_W-1:0] code);
    return (code != OP_IF) && (code != OP_BACK);
  endfunction

endpackage

// File: rtl/bf_bracket_stack.sv
// Synchronous LIFO holding the addresses of open '[' instructions.
module bf_bracket_stack
  import bf_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned PTR_W = IDX_W + 1;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [IDX_W-1:0]  top_idx;

  always_comb begin
    sp_d = sp_q;
    if (clear_i)                sp_d = '0;
    else if (push_i && !full_o) sp_d = sp_q + PTR_W'(1);
    else if (pop_i && !empty_o) sp_d = sp_q - PTR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  // Entry storage needs no reset; the pointer alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push_i && !full_o && !clear_i) mem_q[sp_q[IDX_W-1:0]] <= data_i;
  end

  assign top_idx = IDX_W'(sp_q - PTR_W'(1));
  assign top_o   = mem_q[top_idx];
  assign full_o  = (sp_q == PTR_W'(DEPTH));
  assign empty_o = (sp_q == '0);

endmodule

// File: rtl/bf_fetch_ctrl.sv
// Brainfuck instruction sequencer: owns pc, issues data ops, resolves brackets locally.
// Optional BF_STEP_EN adds step_i, limiting RUN to one retired instruction per pulse.
module bf_fetch_ctrl
  import bf_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
`ifdef BF_STEP_EN
  input  logic              step_i,
`endif
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [OP_W-1:0]   rom_code_i,
  input  logic              rom_overrun_i,
  output logic              op_valid_o,
  output logic [OP_W-1:0]   op_code_o,
  input  logic              op_ready_i,
  input  logic              cell_zero_i,
  output logic              busy_o,
  output logic              halted_o,
  output logic              error_o
);

  localparam int unsigned DEPTH_W = $clog2(STACK_DEPTH) + 1;

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q, pc_d, pc_inc, top;
  logic [DEPTH_W-1:0] depth_q, depth_d;
  logic               push, pop, clear, full, empty;
  logic               go, retire, is_data;

  assign pc_inc     = pc_q + ADDR_W'(1);
  assign is_data    = is_data_op(rom_code_i);
  assign rom_addr_o = pc_q;

`ifdef BF_STEP_EN
  logic [1:0] credit_q, credit_d;

  // Step pulses bank as credits; each retired instruction spends one.
  always_comb begin
    credit_d = credit_q;
    if (clear) begin
      credit_d = '0;
    end else if (retire && !step_i) begin
      credit_d = credit_q - 2'd1;
    end else if (step_i && !retire && (credit_q != 2'd3)) begin
      credit_d = credit_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) credit_q <= '0;
    else     credit_q <= credit_d;
  end

  assign go = (credit_q != 2'd0);
`else
  logic unused_retire;
  assign unused_retire = retire;
  assign go            = 1'b1;
`endif

  bf_bracket_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (STACK_DEPTH)
  ) u_stack (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (pc_q),
    .top_o   (top),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      depth_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      depth_q <= depth_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    depth_d = depth_q;
    push    = 1'b0;
    pop     = 1'b0;
    clear   = 1'b0;
    retire  = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT, ST_ERR: begin
        if (start_i) begin
          state_d = ST_RUN;
          pc_d    = '0;
          depth_d = '0;
          clear   = 1'b1;
        end
      end
      ST_RUN: begin
        if (rom_overrun_i) begin
          state_d = ST_HALT;
        end else if (go) begin
          if (is_data) begin
            if (op_ready_i) begin
              pc_d   = pc_inc;
              retire = 1'b1;
            end
          end else if (rom_code_i == OP_IF) begin
            retire = 1'b1;
            if (cell_zero_i) begin
              depth_d = DEPTH_W'(1);
              pc_d    = pc_inc;
              state_d = ST_SKIP;
            end else if (full) begin
              state_d = ST_ERR;
            end else begin
              push = 1'b1;
              pc_d = pc_inc;
            end
          end else begin
            retire = 1'b1;
            if (empty)             state_d = ST_ERR;
            else if (!cell_zero_i) pc_d = top + ADDR_W'(1);
            else begin
              pop  = 1'b1;
              pc_d = pc_inc;
            end
          end
        end
      end
      ST_SKIP: begin
        pc_d = pc_inc;
        if (rom_overrun_i) begin
          state_d = ST_ERR;
          pc_d    = pc_q;
        end else if (rom_code_i == OP_IF) begin
          if (depth_q == '1) state_d = ST_ERR;
          else               depth_d = depth_q + DEPTH_W'(1);
        end else if (rom_code_i == OP_BACK) begin
          depth_d = depth_q - DEPTH_W'(1);
          if (depth_q == DEPTH_W'(1)) state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Zero-latency issue: the opcode under pc is offered in the same cycle.
  always_comb begin
    op_valid_o = 1'b0;
    op_code_o  = '0;
    busy_o     = (state_q == ST_RUN) || (state_q == ST_SKIP);
    halted_o   = (state_q == ST_HALT);
    error_o    = (state_q == ST_ERR);
    if ((state_q == ST_RUN) && !rom_overrun_i && go && is_data) begin
      op_valid_o = 1'b1;
      op_code_o  = rom_code_i;
    end
  end

endmodule

// File: tb/tb_bf_fetch_ctrl.sv
// Bench for bf_fetch_ctrl: directed per-cycle vector table, then random programs
// checked against a bracket-matching Brainfuck interpreter.
module tb_bf_fetch_ctrl;

  localparam int unsigned AW = 10;
  localparam logic [2:0] C_IN = 3'b000, C_OUT = 3'b001, C_BACK = 3'b010, C_IF = 3'b011;
  localparam logic [2:0] C_MOVL = 3'b100, C_MOVR = 3'b101, C_DEC = 3'b110, C_INC = 3'b111;

  logic          clk = 1'b0;
  logic          rst, start_i, op_ready_i, cell_zero_i, rom_overrun_i;
  logic          op_valid_o, busy_o, halted_o, error_o;
  logic [AW-1:0] rom_addr_o;
  logic [2:0]    rom_code_i, op_code_o;

  logic [2:0] rom_mem [64];
  int         rom_len = 0;
  int         total = 0;
  int         bad = 0;
  logic [2:0] exp_q [$];
  logic [7:0] dt [32];
  int         dptr;

  always #5 clk = ~clk;

  bf_fetch_ctrl #(.ADDR_W(AW), .STACK_DEPTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .rom_addr_o    (rom_addr_o),
    .rom_code_i    (rom_code_i),
    .rom_overrun_i (rom_overrun_i),
    .op_valid_o    (op_valid_o),
    .op_code_o     (op_code_o),
    .op_ready_i    (op_ready_i),
    .cell_zero_i   (cell_zero_i),
    .busy_o        (busy_o),
    .halted_o      (halted_o),
    .error_o       (error_o)
  );

  // Combinational program ROM
  always_comb begin
    rom_overrun_i = (int'(rom_addr_o) >= rom_len);
    rom_code_i    = rom_overrun_i ? 3'b000 : rom_mem[rom_addr_o[5:0]];
  end

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [2:0] code_of(input byte c);
    case (c)
      "+": return C_INC;
      "-": return C_DEC;
      ">": return C_MOVR;
      "<": return C_MOVL;
      "[": return C_IF;
      "]": return C_BACK;
      ".": return C_OUT;
      default: return C_IN;
    endcase
  endfunction

  task automatic load_prog(input string s);
    rom_len = s.len();
    for (int i = 0; i < s.len(); i++) rom_mem[i] = code_of(s[i]);
  endtask

  function automatic logic [7:0] cell_after(input logic [2:0] op, input logic [7:0] v);
    if (op == C_INC) return v + 8'd1;
    if (op == C_DEC) return v - 8'd1;
    if (op == C_IN)  return 8'd5;
    return v;
  endfunction

  function automatic int ptr_after(input logic [2:0] op, input int p);
    if (op == C_MOVR) return (p + 1) % 32;
    if (op == C_MOVL) return (p + 31) % 32;
    return p;
  endfunction

  // Interpreter over a precomputed bracket match table; yields the data-op stream.
  task automatic ref_model(output bit fin);
    int match [64];
    int stk [64];
    int sp, pc, steps, ptr;
    logic [7:0] mt [32];
    sp = 0;
    exp_q.delete();
    for (int i = 0; i < rom_len; i++) begin
      match[i] = 0;
      if (rom_mem[i] == C_IF) begin
        stk[sp] = i;
        sp++;
      end else if (rom_mem[i] == C_BACK) begin
        sp--;
        match[i] = stk[sp];
        match[stk[sp]] = i;
      end
    end
    foreach (mt[j]) mt[j] = 8'd0;
    pc = 0; ptr = 0; steps = 0;
    while (pc < rom_len && steps < 600) begin
      steps++;
      if (rom_mem[pc] == C_IF)        pc = (mt[ptr] == 8'd0) ? match[pc] + 1 : pc + 1;
      else if (rom_mem[pc] == C_BACK) pc = (mt[ptr] != 8'd0) ? match[pc] + 1 : pc + 1;
      else begin
        exp_q.push_back(rom_mem[pc]);
        mt[ptr] = cell_after(rom_mem[pc], mt[ptr]);
        ptr = ptr_after(rom_mem[pc], ptr);
        pc++;
      end
    end
    fin = (pc >= rom_len);
  endtask

  // Balanced random program, nesting at most 3
  task automatic gen_prog();
    logic [2:0] dops [8];
    int n, open, len, r;
    dops = '{C_INC, C_DEC, C_INC, C_DEC, C_MOVR, C_MOVL, C_OUT, C_IN};
    len = $urandom_range(4, 20);
    n = 0; open = 0;
    for (int i = 0; i < len; i++) begin
      r = $urandom_range(0, 7);
      if (r == 0 && open < 3) begin
        rom_mem[n] = C_IF; open++;
      end else if (r == 1 && open > 0) begin
        rom_mem[n] = C_BACK; open--;
      end else begin
        rom_mem[n] = dops[$urandom_range(0, 7)];
      end
      n++;
    end
    while (open > 0) begin
      rom_mem[n] = C_BACK; open--; n++;
    end
    rom_len = n;
  endtask

  typedef struct {
    logic rst, start, ready, cz;
    int   prog;
    int   addr;
    logic valid;
    logic [2:0] code;
    logic busy, halt, err;
  } vec_t;
  vec_t vq [$];

  task automatic add(input logic r, s, rd, cz, input int p, input int a,
                     input logic v, input logic [2:0] c, input logic b, h, e);
    vec_t t;
    t.rst = r; t.start = s; t.ready = rd; t.cz = cz; t.prog = p; t.addr = a;
    t.valid = v; t.code = c; t.busy = b; t.halt = h; t.err = e;
    vq.push_back(t);
  endtask

  function automatic int pack_out();
    return {15'd0, rom_addr_o, op_valid_o, op_code_o, busy_o, halted_o, error_o};
  endfunction

  function automatic int pack_exp(input vec_t t);
    return {15'd0, AW'(t.addr), t.valid, t.code, t.busy, t.halt, t.err};
  endfunction

  string progs [6];

  initial begin
    int  cur;
    bit  fin, pend;
    logic [2:0] prev_code, e;
    progs = '{"++>-.", "[+]", "+[-]", "[[]]", "]", "[[[[[[[[[[[[[[[[["};

    // rst start rdy cz prog | addr valid code busy halt err
    add(0,0,1,0,0, 0,0,0,0,0,0);
    add(0,1,1,0,0, 0,0,0,0,0,0);
    repeat (3) add(0,0,0,0,0, 0,1,7,1,0,0);
    add(0,0,1,0,0, 0,1,7,1,0,0);
    add(0,0,1,0,0, 1,1,7,1,0,0);
    add(0,1,1,0,0, 2,1,5,1,0,0);
    add(0,0,1,0,0, 3,1,6,1,0,0);
    add(0,0,1,0,0, 4,1,1,1,0,0);
    add(0,0,1,0,0, 5,0,0,1,0,0);
    add(0,0,1,0,0, 5,0,0,0,1,0);
    add(0,0,1,0,0, 5,0,0,0,1,0);
    // [+] with the cell at zero: skipped without issuing anything
    add(0,1,1,1,1, 5,0,0,0,1,0);
    for (int k = 0; k < 4; k++) add(0,0,1,1,1, k,0,0,1,0,0);
    add(0,0,1,1,1, 3,0,0,0,1,0);
    // +[-]: two loop-backs then exit
    add(0,1,1,0,2, 3,0,0,0,1,0);
    add(0,0,1,0,2, 0,1,7,1,0,0);
    add(0,0,1,0,2, 1,0,0,1,0,0);
    for (int k = 0; k < 2; k++) begin
      add(0,0,1,0,2, 2,1,6,1,0,0);
      add(0,0,1,0,2, 3,0,0,1,0,0);
    end
    add(0,0,1,0,2, 2,1,6,1,0,0);
    add(0,0,1,1,2, 3,0,0,1,0,0);
    add(0,0,1,1,2, 4,0,0,1,0,0);
    add(0,0,1,1,2, 4,0,0,0,1,0);
    // [[]] nested skip
    add(0,1,1,1,3, 4,0,0,0,1,0);
    for (int k = 0; k < 5; k++) add(0,0,1,1,3, k,0,0,1,0,0);
    add(0,0,1,1,3, 4,0,0,0,1,0);
    // lone ]
    add(0,1,1,0,4, 4,0,0,0,1,0);
    add(0,0,1,0,4, 0,0,0,1,0,0);
    add(0,0,1,0,4, 0,0,0,0,0,1);
    add(0,0,1,0,4, 0,0,0,0,0,1);
    // 17 nested [ overflow a 16-entry stack
    add(0,1,1,0,5, 0,0,0,0,0,1);
    for (int k = 0; k < 17; k++) add(0,0,1,0,5, k,0,0,1,0,0);
    add(0,0,1,0,5, 16,0,0,0,0,1);
    // reset with a handshake pending
    add(0,1,1,0,0, 16,0,0,0,0,1);
    add(0,0,1,0,0, 0,1,7,1,0,0);
    add(1,0,0,0,0, 1,1,7,1,0,0);
    add(0,0,1,0,0, 0,0,0,0,0,0);
    add(0,0,1,0,0, 0,0,0,0,0,0);

    rst = 1'b1; start_i = 1'b0; op_ready_i = 1'b0; cell_zero_i = 1'b0;
    repeat (2) @(posedge clk);
    cur = -1;
    foreach (vq[i]) begin
      @(negedge clk);
      if (vq[i].prog != cur) begin
        load_prog(progs[vq[i].prog]);
        cur = vq[i].prog;
      end
      rst = vq[i].rst; start_i = vq[i].start;
      op_ready_i = vq[i].ready; cell_zero_i = vq[i].cz;
      #1;
      check($sformatf("vec%0d", i), pack_out(), pack_exp(vq[i]));
    end

    // Random programs, random back-pressure, execute-unit tape model
    for (int p = 0; p < 20; p++) begin
      fin = 1'b0;
      for (int t = 0; t < 50 && !fin; t++) begin
        gen_prog();
        ref_model(fin);
      end
      if (!fin) continue;
      foreach (dt[j]) dt[j] = 8'd0;
      dptr = 0; pend = 1'b0; prev_code = 3'b000;
      @(negedge clk);
      start_i = 1'b1; op_ready_i = 1'b0; cell_zero_i = 1'b1;
      for (int cyc = 0; cyc < 20000; cyc++) begin
        @(negedge clk);
        start_i = 1'b0;
        if (halted_o || error_o) break;
        op_ready_i = ($urandom_range(0, 3) != 0);
        if (pend) check("rand_hold", int'({op_valid_o, op_code_o}), int'({1'b1, prev_code}));
        if (op_valid_o && op_ready_i) begin
          if (exp_q.size() == 0) begin
            check("rand_extra_op", int'(op_code_o), -1);
          end else begin
            e = exp_q.pop_front();
            check("rand_op", int'(op_code_o), int'(e));
          end
          dt[dptr] = cell_after(op_code_o, dt[dptr]);
          dptr = ptr_after(op_code_o, dptr);
          cell_zero_i = (dt[dptr] == 8'd0);
        end
        pend = op_valid_o && !op_ready_i;
        prev_code = op_code_o;
      end
      check($sformatf("rand_end%0d", p), int'({halted_o, error_o}), 2);
      check($sformatf("rand_left%0d", p), exp_q.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
